// File: rtl/versat_reg_if.sv
// Memory-mapped host port of the Versat register unit.
interface versat_reg_if #(
  parameter int DATA_W = 8
);
  logic                  valid;
  logic [1:0]            addr;
  logic [DATA_W/8-1:0]   wstrb;
  logic [DATA_W-1:0]     wdata;
  logic                  rvalid;
  logic [DATA_W-1:0]     rdata;

  modport master (output valid, addr, wstrb, wdata, input rvalid, rdata);
  modport slave  (input valid, addr, wstrb, wdata, output rvalid, rdata);
endinterface

// File: rtl/versat_reg.sv
// Versat register unit: captures in0 after delay0 running cycles, host-accessible
// through a single aliased memory-mapped register.
module versat_reg_unit #(
  parameter int DELAY_W = 2,
  parameter int DATA_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_W-1:0]  in0,
  output logic [DATA_W-1:0]  out0,
  input  logic               running,
  input  logic               run,
  output logic               done,
  input  logic               disabled,
  output logic [DATA_W-1:0]  currentValue,
  input  logic [DELAY_W-1:0] delay0,
  versat_reg_if.slave        mm
);
  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0]  stored;
  logic [DELAY_W-1:0] cnt;
  logic               busy;
  logic               mm_wr, mm_rd, capture;
  logic [DATA_W-1:0]  wr_merged;

  assign mm_wr = mm.valid && (mm.wstrb != '0);
  assign mm_rd = mm.valid && (mm.wstrb == '0);

  // Capture only on a counted-out running cycle that is not restarted or aborted.
  assign capture = !run && busy && !disabled && running && (cnt == '0);

  for (genvar b = 0; b < NB; b++) begin : g_byte
    assign wr_merged[b*8 +: 8] = mm.wstrb[b] ? mm.wdata[b*8 +: 8] : stored[b*8 +: 8];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stored    <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      mm.rvalid <= 1'b0;
      mm.rdata  <= '0;
    end else begin
      if (run) begin
        if (!disabled) begin
          cnt  <= delay0;
          busy <= 1'b1;
        end else begin
          busy <= 1'b0;
        end
      end else if (busy) begin
        if (disabled)
          busy <= 1'b0;
        else if (running) begin
          if (cnt == '0) busy <= 1'b0;
          else           cnt  <= cnt - 1'b1;
        end
      end

      // Host write beats a same-cycle capture; busy has already cleared above.
      if (mm_wr)        stored <= wr_merged;
      else if (capture) stored <= in0;

      mm.rvalid <= mm_rd;
      if (mm_rd) mm.rdata <= stored;
    end
  end

  assign out0         = stored;
  assign currentValue = stored;
  assign done         = ~busy;
endmodule

// File: tb/tb_versat_reg_unit.sv
// Scoreboard bench for versat_reg_unit: directed test-plan sequences then random traffic.
module tb_versat_reg_unit;
  localparam int DELAY_W = 2;
  localparam int DATA_W  = 8;
  localparam int NB      = DATA_W / 8;

  typedef struct {
    logic              rst, run, running, disabled, valid;
    logic [DELAY_W-1:0] delay0;
    logic [DATA_W-1:0]  in0, wdata;
    logic [1:0]         addr;
    logic [NB-1:0]      wstrb;
  } stim_t;

  typedef struct {
    logic [DATA_W-1:0] stored;
    logic              done, rvalid;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [DATA_W-1:0]  in0, out0, currentValue;
  logic               running, run, done, disabled;
  logic [DELAY_W-1:0] delay0;

  versat_reg_if #(.DATA_W(DATA_W)) mm();

  versat_reg_unit #(.DELAY_W(DELAY_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .in0(in0), .out0(out0), .running(running), .run(run),
    .done(done), .disabled(disabled), .currentValue(currentValue), .delay0(delay0),
    .mm(mm.slave)
  );

  always #5 clk = ~clk;

  exp_t              st_q[$];
  logic [DATA_W-1:0] rd_q[$];
  int n_checks = 0, n_fail = 0;

  // Reference model: value plus number of running cycles still owed before capture.
  logic [DATA_W-1:0] m_stored = '0;
  int                m_left   = 0;

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick(input stim_t s);
    exp_t e;
    bit   cap, rd;
    @(negedge clk);
    rst = s.rst; run = s.run; running = s.running; disabled = s.disabled;
    delay0 = s.delay0; in0 = s.in0;
    mm.valid = s.valid; mm.addr = s.addr; mm.wstrb = s.wstrb; mm.wdata = s.wdata;
    rd = 1'b0;
    if (s.rst) begin
      m_stored = '0;
      m_left   = 0;
    end else begin
      cap = 1'b0;
      rd  = s.valid && (s.wstrb == '0);
      if (rd) rd_q.push_back(m_stored);
      if (s.run) m_left = s.disabled ? 0 : int'(s.delay0) + 1;
      else if (m_left > 0) begin
        if (s.disabled) m_left = 0;
        else if (s.running) begin
          m_left--;
          cap = (m_left == 0);
        end
      end
      if (s.valid && s.wstrb != '0) begin
        for (int b = 0; b < NB; b++)
          if (s.wstrb[b]) m_stored[b*8 +: 8] = s.wdata[b*8 +: 8];
      end else if (cap) m_stored = s.in0;
    end
    e.stored = m_stored;
    e.done   = (m_left == 0);
    e.rvalid = rd;
    st_q.push_back(e);
  endtask

  function automatic stim_t idle();
    stim_t s;
    s.rst = 0; s.run = 0; s.running = 0; s.disabled = 0; s.valid = 0;
    s.delay0 = '0; s.in0 = '0; s.wdata = '0; s.addr = '0; s.wstrb = '0;
    return s;
  endfunction

  // Monitor: compares every post-edge DUT state against the queued expectations.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (st_q.size() > 0) begin
        e = st_q.pop_front();
        check("out0", out0, e.stored);
        check("currentValue", currentValue, e.stored);
        check("done", {7'd0, done}, {7'd0, e.done});
        check("rvalid", {7'd0, mm.rvalid}, {7'd0, e.rvalid});
        if (mm.rvalid) begin
          if (rd_q.size() == 0) check("rdata_unexpected", 8'h01, 8'h00);
          else check("rdata", mm.rdata, rd_q.pop_front());
        end
      end
    end
  end

  initial begin
    stim_t s;
    int    guard;
    rst = 1; run = 0; running = 0; disabled = 0; delay0 = '0; in0 = '0;
    mm.valid = 0; mm.addr = '0; mm.wstrb = '0; mm.wdata = '0;

    // 1. reset
    s = idle(); s.rst = 1; tick(s);
    // 2. delayed capture, delay0=3
    s = idle(); s.run = 1; s.delay0 = 3; s.in0 = 8'hFF; tick(s);
    s = idle(); s.running = 1; s.in0 = 8'hFF; repeat (4) tick(s);
    s = idle(); tick(s);
    // 3. zero delay
    s = idle(); s.run = 1; s.delay0 = 0; tick(s);
    s = idle(); s.running = 1; s.in0 = 8'h00; tick(s);
    s = idle(); tick(s);
    // 4. host write, then run with delay0=1
    s = idle(); s.valid = 1; s.wstrb = 1; s.wdata = 8'hFF; s.addr = 2'($urandom); tick(s);
    s = idle(); s.run = 1; s.delay0 = 1; tick(s);
    s = idle(); s.running = 1; s.in0 = 8'h00; repeat (2) tick(s);
    s = idle(); tick(s);
    // 5. reads while disabled, and a disabled run
    s = idle(); s.disabled = 1; s.valid = 1; s.addr = 3; repeat (3) tick(s);
    s = idle(); s.disabled = 1; s.run = 1; s.in0 = 8'h77; tick(s);
    s = idle(); s.disabled = 1; s.running = 1; s.in0 = 8'h77; repeat (2) tick(s);
    // 6. write beats capture; reset mid-run
    s = idle(); s.run = 1; s.delay0 = 0; tick(s);
    s = idle(); s.running = 1; s.in0 = 8'h3C; s.valid = 1; s.wstrb = 1; s.wdata = 8'hA5; tick(s);
    s = idle(); s.valid = 1; tick(s);
    s = idle(); s.run = 1; s.delay0 = 3; tick(s);
    s = idle(); s.running = 1; s.in0 = 8'h5A; tick(s);
    s = idle(); s.rst = 1; s.running = 1; tick(s);
    s = idle(); s.running = 1; s.in0 = 8'h5A; repeat (4) tick(s);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      s = idle();
      s.rst      = ($urandom_range(63) == 0);
      s.run      = ($urandom_range(7) == 0);
      s.running  = ($urandom_range(3) != 0);
      s.disabled = ($urandom_range(9) == 0);
      s.delay0   = DELAY_W'($urandom);
      s.in0      = DATA_W'($urandom);
      s.valid    = ($urandom_range(3) == 0);
      s.addr     = 2'($urandom);
      s.wstrb    = NB'($urandom);
      s.wdata    = DATA_W'($urandom);
      tick(s);
    end

    s = idle(); tick(s);
    guard = 0;
    while (st_q.size() > 0 && guard < 20) begin
      @(posedge clk); #2;
      guard++;
    end
    check("scoreboard_drained", 8'(st_q.size() + rd_q.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
